// File: rtl/rtype_issue_stage.sv
// rtype_issue_stage - R-type decode/operand-fetch stage feeding the ALU.
// Holds a 32x32 register file with writeback bypass and a single registered issue slot.
module rtype_issue_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       out_funct,
    output logic [4:0]       out_shamt,
    output logic [31:0]      out_a,
    output logic [31:0]      out_b,
    output logic [4:0]       out_rd,
    input  logic             wb_en,
    input  logic [4:0]       wb_addr,
    input  logic [31:0]      wb_data,
    output logic             illegal,
    output logic [CNT_W-1:0] issue_count
);

    logic [31:0]      rf_q [0:31];

    logic             valid_q, valid_d;
    logic [5:0]       funct_q, funct_d;
    logic [4:0]       shamt_q, shamt_d;
    logic [4:0]       rd_q, rd_d;
    logic [4:0]       rs_q, rs_d;
    logic [4:0]       rt_q, rt_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [4:0]       in_rs, in_rt;
    logic [31:0]      fetch_a, fetch_b;
    logic             legal, accept, wb_live;

    assign in_rs   = in_instr[25:21];
    assign in_rt   = in_instr[20:16];
    assign wb_live = wb_en && (wb_addr != 5'd0);

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        legal = 1'b0;
        if (in_instr[31:26] == 6'd0) begin
            case (in_instr[5:0])
                6'h00, 6'h02, 6'h03, 6'h04,
                6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: legal = 1'b1;
                default:                           legal = 1'b0;
            endcase
        end
    end

    // Writeback landing this edge is forwarded so the issued operand is never stale.
    always_comb begin
        fetch_a = rf_q[in_rs];
        fetch_b = rf_q[in_rt];
        if (in_rs == 5'd0)
            fetch_a = 32'd0;
        else if (wb_live && wb_addr == in_rs)
            fetch_a = wb_data;
        if (in_rt == 5'd0)
            fetch_b = 32'd0;
        else if (wb_live && wb_addr == in_rt)
            fetch_b = wb_data;
    end

    always_comb begin
        valid_d   = valid_q && !out_ready;
        funct_d   = funct_q;
        shamt_d   = shamt_q;
        rd_d      = rd_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        a_d       = a_q;
        b_d       = b_q;
        illegal_d = accept && !legal;
        count_d   = count_q;

        if (accept && legal) begin
            valid_d = 1'b1;
            funct_d = in_instr[5:0];
            shamt_d = in_instr[10:6];
            rd_d    = in_instr[15:11];
            rs_d    = in_rs;
            rt_d    = in_rt;
            a_d     = fetch_a;
            b_d     = fetch_b;
            count_d = count_q + CNT_W'(1);
        end else if (valid_q && !out_ready) begin
            // A stalled slot tracks writebacks to its sources so it issues current values.
            if (wb_live && wb_addr == rs_q)
                a_d = wb_data;
            if (wb_live && wb_addr == rt_q)
                b_d = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            funct_q   <= 6'd0;
            shamt_q   <= 5'd0;
            rd_q      <= 5'd0;
            rs_q      <= 5'd0;
            rt_q      <= 5'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            valid_q   <= valid_d;
            funct_q   <= funct_d;
            shamt_q   <= shamt_d;
            rd_q      <= rd_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++)
                rf_q[i] <= 32'd0;
        end else if (wb_live) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    assign out_valid   = valid_q;
    assign out_funct   = funct_q;
    assign out_shamt   = shamt_q;
    assign out_a       = a_q;
    assign out_b       = b_q;
    assign out_rd      = rd_q;
    assign illegal     = illegal_q;
    assign issue_count = count_q;

endmodule

// File: tb/tb_rtype_issue_stage.sv
// tb/tb_rtype_issue_stage.sv - directed self-checking bench for rtype_issue_stage.
module tb_rtype_issue_stage;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_instr = 32'd0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [5:0]       out_funct;
    logic [4:0]       out_shamt;
    logic [31:0]      out_a;
    logic [31:0]      out_b;
    logic [4:0]       out_rd;
    logic             wb_en = 1'b0;
    logic [4:0]       wb_addr = 5'd0;
    logic [31:0]      wb_data = 32'd0;
    logic             illegal;
    logic [CNT_W-1:0] issue_count;

    int errors = 0;
    int checks = 0;

    rtype_issue_stage #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_funct(out_funct), .out_shamt(out_shamt),
        .out_a(out_a), .out_b(out_b), .out_rd(out_rd),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .illegal(illegal), .issue_count(issue_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset
        step();
        reset = 1'b0;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_count", 32'(issue_count), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_a", out_a, 32'd0);
        chk("rst_funct", 32'(out_funct), 32'd0);

        // write R8=5, then add rd=10 rs=8 rt=0
        wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'h5;
        step();
        wb_en = 1'b0;
        in_valid = 1'b1; in_instr = 32'h0100_5020;
        step();
        in_valid = 1'b0;
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_funct", 32'(out_funct), 32'h20);
        chk("add_a", out_a, 32'd5);
        chk("add_b", out_b, 32'd0);
        chk("add_rd", 32'(out_rd), 32'd10);
        chk("add_count", 32'(issue_count), 32'd1);

        // bypass: sub rs=9 rt=9 with same-cycle writeback of R9
        in_valid = 1'b1; in_instr = 32'h0129_0822;
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hFFFF_FFFF;
        step();
        chk("byp_a", out_a, 32'hFFFF_FFFF);
        chk("byp_b", out_b, 32'hFFFF_FFFF);
        chk("byp_funct", 32'(out_funct), 32'h22);
        chk("byp_count", 32'(issue_count), 32'd2);
        in_instr = 32'h0000_0822; wb_addr = 5'd0; wb_data = 32'hDEAD_BEEF;
        step();
        wb_en = 1'b0;
        chk("r0_a", out_a, 32'd0);
        chk("r0_b", out_b, 32'd0);
        chk("r0_count", 32'(issue_count), 32'd3);

        // add rd=2 rs=9 rt=8 reads both file entries
        in_instr = 32'h0128_1020;
        step();
        chk("rd9_a", out_a, 32'hFFFF_FFFF);
        chk("rd8_b", out_b, 32'd5);
        chk("rd_count", 32'(issue_count), 32'd4);

        // backpressure: or rd=3 rs=8 rt=9 waits
        out_ready = 1'b0; in_instr = 32'h0109_1825;
        #1;
        chk("bp_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_funct", 32'(out_funct), 32'h20);
            chk("bp_count", 32'(issue_count), 32'd4);
            chk("bp_ready_hold", 32'(in_ready), 32'd0);
        end
        wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'h1234;
        step();
        wb_en = 1'b0;
        chk("refresh_b", out_b, 32'h1234);
        chk("refresh_a", out_a, 32'hFFFF_FFFF);
        chk("refresh_rd", 32'(out_rd), 32'd2);
        out_ready = 1'b1;
        step();
        chk("swap_valid", 32'(out_valid), 32'd1);
        chk("swap_funct", 32'(out_funct), 32'h25);
        chk("swap_a", out_a, 32'h1234);
        chk("swap_b", out_b, 32'hFFFF_FFFF);
        chk("swap_count", 32'(issue_count), 32'd5);
        in_valid = 1'b0;
        step();
        chk("drain_valid", 32'(out_valid), 32'd0);

        // illegal: lw then nor
        in_valid = 1'b1; in_instr = 32'h8C00_0000;
        step();
        chk("ill_lw", 32'(illegal), 32'd1);
        chk("ill_lw_valid", 32'(out_valid), 32'd0);
        in_instr = 32'h0000_0027;
        step();
        chk("ill_nor", 32'(illegal), 32'd1);
        chk("ill_nor_valid", 32'(out_valid), 32'd0);
        chk("ill_count", 32'(issue_count), 32'd5);
        in_valid = 1'b0;
        step();
        chk("ill_clear", 32'(illegal), 32'd0);

        // shift fields and nop
        in_valid = 1'b1; in_instr = 32'h0004_19C2;
        step();
        chk("srl_funct", 32'(out_funct), 32'h02);
        chk("srl_shamt", 32'(out_shamt), 32'd7);
        chk("srl_rd", 32'(out_rd), 32'd3);
        chk("srl_b", out_b, 32'd0);
        chk("srl_count", 32'(issue_count), 32'd6);
        in_instr = 32'h0000_0000;
        step();
        chk("nop_valid", 32'(out_valid), 32'd1);
        chk("nop_illegal", 32'(illegal), 32'd0);
        chk("nop_count", 32'(issue_count), 32'd7);

        // reset with slot full; accept and writeback that cycle are dropped
        out_ready = 1'b0;
        reset = 1'b1; in_instr = 32'h0128_1020;
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h7;
        step();
        reset = 1'b0; wb_en = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_count", 32'(issue_count), 32'd0);
        chk("mrst_funct", 32'(out_funct), 32'd0);
        in_valid = 1'b1; in_instr = 32'h0128_1020;
        step();
        chk("mrst_r9", out_a, 32'd0);
        chk("mrst_r8", out_b, 32'd0);
        in_instr = 32'h00A5_1020;
        step();
        chk("mrst_r5", out_a, 32'd0);
        chk("mrst_count2", 32'(issue_count), 32'd2);

        // counter wrap: 17 legal issues since reset
        in_instr = 32'h0000_0000;
        for (int i = 0; i < 15; i++) begin
            step();
            chk("wrap_count", 32'(issue_count), 32'((3 + i) % 16));
        end
        in_valid = 1'b0;
        step();
        chk("wrap_final", 32'(issue_count), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
